fetch_decode_unit: RTL and testbench

Byte-stream instruction front end for the 6502 core: fetches bytes from a byte-wide memory port into a parametrised prefetch FIFO, assembles complete 1–3 byte instructions, and presents each decoded instruction to the execute stage through a valid/ready handshake. It succeeds the purely combinational prime decoder. It adds prefetch buffering, multiple outstanding reads, operand assembly and pipeline redirect for branches and jumps.

---
 rtl/cpu6502_pkg.sv | 38 +++
 rtl/opcode_len_decode.sv | 55 +++++
 rtl/fetch_decode_unit.sv | 110 +++++++++++
 tb/tb_fetch_decode_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared opcode constants, addressing-mode encodings and decode-result type
package cpu6502_pkg;
   localparam int MODE_X   = 6;
   localparam int MODE_Y   = 5;
   localparam int MODE_ACC = 4;
   localparam int MODE_IMM = 3;
   localparam int MODE_ZP  = 2;
   localparam int MODE_ABS = 1;
   localparam int MODE_IND = 0;

   localparam logic [6:0] M_NONE = 7'b0;
   localparam logic [6:0] M_X    = 7'b1 << MODE_X;
   localparam logic [6:0] M_Y    = 7'b1 << MODE_Y;
   localparam logic [6:0] M_ACC  = 7'b1 << MODE_ACC;
   localparam logic [6:0] M_IMM  = 7'b1 << MODE_IMM;
   localparam logic [6:0] M_ZP   = 7'b1 << MODE_ZP;
   localparam logic [6:0] M_ABS  = 7'b1 << MODE_ABS;
   localparam logic [6:0] M_IND  = 7'b1 << MODE_IND;
   localparam logic [6:0] M_IZX  = M_X | M_ZP | M_IND;
   localparam logic [6:0] M_IZY  = M_Y | M_ZP | M_IND;
   localparam logic [6:0] M_ZPX  = M_X | M_ZP;
   localparam logic [6:0] M_ZPY  = M_Y | M_ZP;
   localparam logic [6:0] M_ABX  = M_X | M_ABS;
   localparam logic [6:0] M_ABY  = M_Y | M_ABS;

   localparam logic [7:0] BRK     = 8'h00;
   localparam logic [7:0] RTI     = 8'h40;
   localparam logic [7:0] RTS     = 8'h60;
   localparam logic [7:0] JSR     = 8'h20;
   localparam logic [7:0] JMP_IND = 8'h6C;

   typedef struct packed {
      logic [1:0] len;
      logic [6:0] mode;
      logic       rel;
      logic       illegal;
   } dec_t;
endpackage

// File: rtl/opcode_len_decode.sv
// opcode_len_decode: combinational 6502 opcode to length/addressing-mode decode
module opcode_len_decode
   import cpu6502_pkg::*;
(
   input  logic [7:0] i_opcode,
   output dec_t       o_dec
);
   logic [1:0] w_cc;
   logic [2:0] w_bbb;
   logic       w_use_y;
   logic [6:0] w_ix;
   assign w_cc    = i_opcode[1:0];
   assign w_bbb   = i_opcode[4:2];
   // STX/LDX index with Y where every other cc=00/10 opcode uses X
   assign w_use_y = (w_cc == 2'b10) && (i_opcode[7:6] == 2'b10);
   assign w_ix    = w_use_y ? M_Y : M_X;
   always_comb begin
      o_dec = '{len: 2'd1, mode: M_NONE, rel: 1'b0, illegal: 1'b0};
      if (i_opcode == BRK || i_opcode == RTI || i_opcode == RTS) begin
         o_dec.len = 2'd1;
      end else if (i_opcode == JSR) begin
         o_dec.len  = 2'd3;
         o_dec.mode = M_ABS;
      end else if (i_opcode == JMP_IND) begin
         o_dec.len  = 2'd3;
         o_dec.mode = M_ABS | M_IND;
      end else if (i_opcode[4:0] == 5'b10000) begin
         o_dec.len = 2'd2;
         o_dec.rel = 1'b1;
      end else if (i_opcode[3:0] == 4'b1000) begin
         o_dec.len = 2'd1;
      end else if (i_opcode[3:0] == 4'b1010) begin
         o_dec.mode = i_opcode[7] ? M_NONE : M_ACC;
      end else if (w_cc == 2'b01) begin
         case (w_bbb)
            3'd0: o_dec = '{len: 2'd2, mode: M_IZX, rel: 1'b0, illegal: 1'b0};
            3'd1: o_dec = '{len: 2'd2, mode: M_ZP,  rel: 1'b0, illegal: 1'b0};
            3'd2: o_dec = '{len: 2'd2, mode: M_IMM, rel: 1'b0, illegal: 1'b0};
            3'd3: o_dec = '{len: 2'd3, mode: M_ABS, rel: 1'b0, illegal: 1'b0};
            3'd4: o_dec = '{len: 2'd2, mode: M_IZY, rel: 1'b0, illegal: 1'b0};
            3'd5: o_dec = '{len: 2'd2, mode: M_ZPX, rel: 1'b0, illegal: 1'b0};
            3'd6: o_dec = '{len: 2'd3, mode: M_ABY, rel: 1'b0, illegal: 1'b0};
            default: o_dec = '{len: 2'd3, mode: M_ABX, rel: 1'b0, illegal: 1'b0};
         endcase
      end else if (w_cc != 2'b11 && (w_bbb[0] || w_bbb == 3'd0)) begin
         o_dec.len  = w_bbb[1] ? 2'd3 : 2'd2;
         o_dec.mode = w_bbb == 3'd0 ? M_IMM :
                      w_bbb == 3'd1 ? M_ZP  :
                      w_bbb == 3'd3 ? M_ABS :
                      w_bbb == 3'd5 ? (w_ix | M_ZP) : (w_ix | M_ABS);
      end else begin
         o_dec.illegal = 1'b1;
      end
   end
endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: byte prefetch FIFO, instruction assembly and redirect for the 6502 front end
module fetch_decode_unit
   import cpu6502_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_pc,
   output logic [7:0]  out_opcode,
   output logic [15:0] out_operand,
   output logic [1:0]  out_len,
   output logic [6:0]  out_mode,
   output logic        out_rel,
   output logic        out_illegal
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_fifo [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt, r_out, r_disc;
   logic [15:0]   r_fpc, r_dpc;
   logic          r_run;
   dec_t          w_dec;
   logic [7:0]    w_b0, w_b1, w_b2;
   logic [15:0]   w_opd;
   logic [CW-1:0] w_len, w_rv;
   logic          w_gnt, w_push, w_load;

   assign w_b0   = r_fifo[r_rd];
   assign w_b1   = r_fifo[r_rd + AW'(1)];
   assign w_b2   = r_fifo[r_rd + AW'(2)];
   assign w_len  = CW'(w_dec.len);
   assign w_rv   = CW'(mem_rvalid);
   assign w_opd  = w_dec.len == 2'd3 ? {w_b2, w_b1} : w_dec.len == 2'd2 ? {8'h00, w_b1} : 16'h0000;
   // outstanding reads reserve FIFO space so returns can never overflow it
   assign mem_req  = r_run && !redirect_valid && (r_out < CW'(MAX_OUT)) && (r_cnt + r_out < CW'(DEPTH));
   assign mem_addr = r_fpc;
   assign w_gnt    = mem_req && mem_gnt;
   assign w_push   = mem_rvalid && r_disc == '0;
   assign w_load   = (!out_valid || out_ready) && r_cnt >= w_len;

   opcode_len_decode u_dec (.i_opcode(w_b0), .o_dec(w_dec));

   always_ff @(posedge clk) begin
      if (w_push && !redirect_valid) r_fifo[r_wr] <= mem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run       <= 1'b0;
         r_rd        <= '0;
         r_wr        <= '0;
         r_cnt       <= '0;
         r_out       <= '0;
         r_disc      <= '0;
         r_fpc       <= 16'h0000;
         r_dpc       <= 16'h0000;
         out_valid   <= 1'b0;
         out_pc      <= 16'h0000;
         out_opcode  <= 8'h00;
         out_operand <= 16'h0000;
         out_len     <= 2'd0;
         out_mode    <= 7'd0;
         out_rel     <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (redirect_valid) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            r_fpc     <= redirect_pc;
            r_dpc     <= redirect_pc;
            r_out     <= r_out - w_rv;
            r_disc    <= r_out - w_rv;
         end else begin
            r_out <= r_out + CW'(w_gnt) - w_rv;
            if (mem_rvalid && r_disc != '0) r_disc <= r_disc - CW'(1);
            if (w_gnt) r_fpc <= r_fpc + 16'd1;
            if (w_push) r_wr <= r_wr + AW'(1);
            r_cnt     <= r_cnt + CW'(w_push) - (w_load ? w_len : '0);
            out_valid <= w_load || (out_valid && !out_ready);
            if (w_load) begin
               r_rd        <= r_rd + AW'(w_dec.len);
               r_dpc       <= r_dpc + 16'(w_dec.len);
               out_pc      <= r_dpc;
               out_opcode  <= w_b0;
               out_operand <= w_opd;
               out_len     <= w_dec.len;
               out_mode    <= w_dec.mode;
               out_rel     <= w_dec.rel;
               out_illegal <= w_dec.illegal;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed checks of fetch, decode, back-pressure, redirect and wrap
module tb_fetch_decode_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        redirect_valid = 1'b0, mem_gnt = 1'b1, mem_rvalid = 1'b0, out_ready = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_req, out_valid, out_rel, out_illegal;
   logic [15:0] mem_addr, out_pc, out_operand;
   logic [7:0]  out_opcode;
   logic [1:0]  out_len;
   logic [6:0]  out_mode;

   int passed = 0, total = 0;
   logic ovf = 1'b0, stall = 1'b0;
   logic [7:0]  mem [0:65535];
   logic [15:0] q[$], glog[$];

   fetch_decode_unit #(.DEPTH(4), .MAX_OUT(2)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_operand(out_operand), .out_len(out_len), .out_mode(out_mode),
      .out_rel(out_rel), .out_illegal(out_illegal));

   always #5 clk = ~clk;

   always @(posedge clk) if (dut.r_cnt > 3'd4) ovf = 1'b1;

   // memory: in-order returns one cycle after grant, held back while stall is set
   always begin
      logic [15:0] a;
      @(negedge clk);
      #2;
      if (rst) begin
         q.delete();
         mem_rvalid = 1'b0;
      end else begin
         if (!stall && q.size() > 0) begin
            a = q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata = mem[a];
         end else mem_rvalid = 1'b0;
         if (mem_req && mem_gnt) begin
            q.push_back(mem_addr);
            glog.push_back(mem_addr);
         end
      end
   end

   function automatic logic [50:0] cur();
      return {out_pc, out_opcode, out_operand, out_len, out_mode, out_rel, out_illegal};
   endfunction

   task automatic get_instr(input string nm, input logic [15:0] pc, input logic [7:0] op,
                            input logic [15:0] opd, input logic [1:0] len, input logic [6:0] mode,
                            input logic rel, input logic ill);
      logic [50:0] exp;
      int n = 0;
      exp = {pc, op, opd, len, mode, rel, ill};
      while (!out_valid && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (!out_valid) $display("FAIL %s: out_valid never rose, want pc=%h", nm, pc);
      else if (cur() !== exp) $display("FAIL %s: got %h required %h", nm, cur(), exp);
      else passed++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b required 0", mem_req); else passed++;
      total++; if (cur() !== 51'd0) $display("FAIL reset_fields: got %h required 0", cur()); else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      total++; if (mem_req !== 1'b1) $display("FAIL first_req: got %b required 1", mem_req); else passed++;
      total++; if (mem_addr !== 16'h0000) $display("FAIL first_addr: got %h required 0000", mem_addr); else passed++;
   endtask

   task automatic test_stream();
      get_instr("lda_imm", 16'h0000, 8'hA9, 16'h0005, 2'd2, 7'b0001000, 1'b0, 1'b0);
      get_instr("sta_abs", 16'h0002, 8'h8D, 16'h0200, 2'd3, 7'b0000010, 1'b0, 1'b0);
      get_instr("nop",     16'h0005, 8'hEA, 16'h0000, 2'd1, 7'b0000000, 1'b0, 1'b0);
   endtask

   task automatic test_decode();
      get_instr("jmp_ind", 16'h0006, 8'h6C, 16'h1234, 2'd3, 7'b0000011, 1'b0, 1'b0);
      get_instr("ldx_zpy", 16'h0009, 8'hB6, 16'h0010, 2'd2, 7'b0100100, 1'b0, 1'b0);
      get_instr("illegal", 16'h000B, 8'hFF, 16'h0000, 2'd1, 7'b0000000, 1'b0, 1'b1);
      get_instr("bne_rel", 16'h000C, 8'hD0, 16'h00FE, 2'd2, 7'b0000000, 1'b1, 1'b0);
   endtask

   task automatic test_hold();
      logic [50:0] snap;
      logic [50:0] exp;
      int n = 0;
      exp = {16'h000E, 8'hEA, 16'h0000, 2'd1, 7'd0, 1'b0, 1'b0};
      while (!out_valid && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      snap = cur();
      total++; if (snap !== exp) $display("FAIL hold_first: got %h required %h", snap, exp); else passed++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (!out_valid || cur() !== exp) $display("FAIL hold_stable%0d: got %b/%h required 1/%h", i, out_valid, cur(), exp);
         else passed++;
      end
      total++; if (mem_req !== 1'b0) $display("FAIL hold_req: got %b required 0", mem_req); else passed++;
      for (int i = 0; i < 5; i++)
         get_instr("hold_release", 16'h000E + 16'(i), 8'hEA, 16'h0000, 2'd1, 7'd0, 1'b0, 1'b0);
   endtask

   task automatic test_redirect();
      stall = 1'b1;
      out_ready = 1'b1;
      for (int n = 0; n < 40 && q.size() != 2; n++) begin
         @(negedge clk);
         #3;
      end
      total++; if (q.size() != 2) $display("FAIL redir_pending: got %0d required 2", q.size()); else passed++;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 16'h8000;
      out_ready = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) $display("FAIL redir_noreq: got %b required 0", mem_req); else passed++;
      @(negedge clk);
      redirect_valid = 1'b0;
      stall = 1'b0;
      get_instr("redir_8000", 16'h8000, 8'hA2, 16'h0007, 2'd2, 7'b0001000, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      logic [15:0] want [3];
      want[0] = 16'hFFFF;
      want[1] = 16'h0000;
      want[2] = 16'h0001;
      mem[16'hFFFF] = 8'h4C;
      mem[16'h0000] = 8'h00;
      mem[16'h0001] = 8'h80;
      @(negedge clk);
      glog.delete();
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      get_instr("wrap_jmp", 16'hFFFF, 8'h4C, 16'h8000, 2'd3, 7'b0000010, 1'b0, 1'b0);
      get_instr("wrap_next", 16'h0002, 8'h8D, 16'h0200, 2'd3, 7'b0000010, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (glog.size() <= i) $display("FAIL wrap_addr%0d: got none required %h", i, want[i]);
         else if (glog[i] !== want[i]) $display("FAIL wrap_addr%0d: got %h required %h", i, glog[i], want[i]);
         else passed++;
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
      mem[0] = 8'hA9; mem[1] = 8'h05; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h02; mem[5] = 8'hEA;
      mem[6] = 8'h6C; mem[7] = 8'h34; mem[8] = 8'h12;
      mem[9] = 8'hB6; mem[10] = 8'h10;
      mem[11] = 8'hFF;
      mem[12] = 8'hD0; mem[13] = 8'hFE;
      mem[16'h8000] = 8'hA2; mem[16'h8001] = 8'h07;
      test_reset();
      test_stream();
      test_decode();
      test_hold();
      test_redirect();
      test_wrap();
      total++; if (ovf !== 1'b0) $display("FAIL fifo_overflow: got %b required 0", ovf); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
